// File: rtl/datapath_sequencer_pkg.sv
// Shared widths, opcode/ALU encodings and FSM state type for the datapath sequencer.
// Instruction layout: opcode | register field | immediate.
package datapath_sequencer_pkg;

    localparam int INSTRUCTION_WIDTH = 16;
    localparam int OPCODE_SIZE       = 4;
    localparam int REGFILE_ADDR_BITS = 4;
    localparam int IMMEDIATE_WIDTH   = 8;
    localparam int DATABUS_SIZE      = 16;
    localparam int ALU_CONTROL_SIZE  = 3;

    localparam logic [OPCODE_SIZE-1:0] OP_ADD  = 4'd0;
    localparam logic [OPCODE_SIZE-1:0] OP_SUB  = 4'd1;
    localparam logic [OPCODE_SIZE-1:0] OP_AND  = 4'd2;
    localparam logic [OPCODE_SIZE-1:0] OP_OR   = 4'd3;
    localparam logic [OPCODE_SIZE-1:0] OP_LOAD = 4'd8;
    localparam logic [OPCODE_SIZE-1:0] OP_NOP  = 4'd14;
    localparam logic [OPCODE_SIZE-1:0] OP_HALT = 4'd15;

    // ALU_NONE is what the datapath sees whenever no ALU operation is active.
    localparam logic [ALU_CONTROL_SIZE-1:0] ALU_NONE = 3'd0;
    localparam logic [ALU_CONTROL_SIZE-1:0] ALU_ADD  = 3'd1;
    localparam logic [ALU_CONTROL_SIZE-1:0] ALU_SUB  = 3'd2;
    localparam logic [ALU_CONTROL_SIZE-1:0] ALU_AND  = 3'd3;
    localparam logic [ALU_CONTROL_SIZE-1:0] ALU_OR   = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        LOAD_WAIT,
        LOAD_WB,
        HALT,
        ERROR
    } state_t;

endpackage

// File: rtl/datapath_sequencer_alu_op_map.sv
// Combinational translation from instruction opcode to ALU control code.
// is_alu flags the opcodes that execute through the ALU.
module alu_op_map
    import datapath_sequencer_pkg::*;
(
    input  logic [OPCODE_SIZE-1:0]      opcode,
    output logic [ALU_CONTROL_SIZE-1:0] alu_ctrl,
    output logic                        is_alu
);

    always_comb begin
        alu_ctrl = ALU_NONE;
        is_alu   = 1'b0;
        case (opcode)
            OP_ADD: begin alu_ctrl = ALU_ADD; is_alu = 1'b1; end
            OP_SUB: begin alu_ctrl = ALU_SUB; is_alu = 1'b1; end
            OP_AND: begin alu_ctrl = ALU_AND; is_alu = 1'b1; end
            OP_OR:  begin alu_ctrl = ALU_OR;  is_alu = 1'b1; end
            default: begin alu_ctrl = ALU_NONE; is_alu = 1'b0; end
        endcase
    end

endmodule

// File: rtl/datapath_sequencer.sv
// Instruction sequencer: fetches, decodes and steps a datapath through ALU and load instructions.
// All handshake and datapath strobes are decoded from the current state, so reset clears them at once.
module datapath_sequencer
    import datapath_sequencer_pkg::*;
#(
    parameter int PC_WIDTH     = 8,
    parameter int LOAD_TIMEOUT = 15
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         imem_req,
    output logic [PC_WIDTH-1:0]          imem_addr,
    input  logic                         imem_ack,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_rdata,
    output logic                         dmem_req,
    output logic [IMMEDIATE_WIDTH-1:0]   dmem_addr,
    input  logic                         dmem_valid,
    input  logic [DATABUS_SIZE-1:0]      dmem_rdata,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic                         write_enable,
    output logic                         data_control,
    output logic [ALU_CONTROL_SIZE-1:0]  control,
    output logic [DATABUS_SIZE-1:0]      load_data,
    input  logic [3:0]                   alu_flags,
    output logic [3:0]                   flags_q,
    output logic                         busy,
    output logic                         halted,
    output logic                         error
);

    localparam int               TMO_W    = $clog2(LOAD_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOAD_TIMEOUT - 1);

    state_t                       state_q, state_d;
    logic [PC_WIDTH-1:0]          pc_q, pc_d;
    logic [INSTRUCTION_WIDTH-1:0] instr_q, instr_d;
    logic [DATABUS_SIZE-1:0]      load_data_q, load_data_d;
    logic [3:0]                   flags_d;
    logic [TMO_W-1:0]             tmo_q, tmo_d;
    logic [OPCODE_SIZE-1:0]       opcode;
    logic [ALU_CONTROL_SIZE-1:0]  alu_ctrl;
    logic                         is_alu;

    assign opcode      = instr_q[INSTRUCTION_WIDTH-1 -: OPCODE_SIZE];
    assign instruction = instr_q;
    assign load_data   = load_data_q;
    assign imem_addr   = pc_q;

    alu_op_map u_alu_op_map (
        .opcode   (opcode),
        .alu_ctrl (alu_ctrl),
        .is_alu   (is_alu)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            instr_q     <= '0;
            load_data_q <= '0;
            flags_q     <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            load_data_q <= load_data_d;
            flags_q     <= flags_d;
            tmo_q       <= tmo_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        load_data_d  = load_data_q;
        flags_d      = flags_q;
        tmo_d        = tmo_q;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_addr    = '0;
        write_enable = 1'b0;
        data_control = 1'b0;
        control      = ALU_NONE;
        busy         = 1'b0;
        halted       = 1'b0;
        error        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    pc_d    = '0;
                end
            end
            FETCH: begin
                busy     = 1'b1;
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                busy = 1'b1;
                if (is_alu) begin
                    state_d = EXEC;
                end else begin
                    case (opcode)
                        OP_LOAD: begin
                            state_d = LOAD_WAIT;
                            tmo_d   = '0;
                        end
                        OP_NOP: begin
                            state_d = FETCH;
                            pc_d    = pc_q + PC_WIDTH'(1);
                        end
                        OP_HALT: state_d = HALT;
                        default: state_d = ERROR;
                    endcase
                end
            end
            EXEC: begin
                busy         = 1'b1;
                write_enable = 1'b1;
                control      = alu_ctrl;
                flags_d      = alu_flags;
                state_d      = FETCH;
                pc_d         = pc_q + PC_WIDTH'(1);
            end
            // A valid on the last allowed cycle is checked before the timeout.
            LOAD_WAIT: begin
                busy      = 1'b1;
                dmem_req  = 1'b1;
                dmem_addr = instr_q[IMMEDIATE_WIDTH-1:0];
                if (dmem_valid) begin
                    load_data_d = dmem_rdata;
                    state_d     = LOAD_WB;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ERROR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            LOAD_WB: begin
                busy         = 1'b1;
                write_enable = 1'b1;
                data_control = 1'b1;
                state_d      = FETCH;
                pc_d         = pc_q + PC_WIDTH'(1);
            end
            HALT: begin
                halted = 1'b1;
                if (start) begin
                    state_d = FETCH;
                    pc_d    = '0;
                    flags_d = '0;
                end
            end
            ERROR: begin
                error = 1'b1;
            end
            default: state_d = ERROR;
        endcase
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed and randomized bench for datapath_sequencer, checked against an instruction-level model
// that tracks pc, flags and the last loaded word.
module tb_datapath_sequencer;
    import datapath_sequencer_pkg::*;

    localparam int PCW = 8;
    localparam int TMO = 15;

    logic                         clk;
    logic                         rst_n;
    logic                         start;
    logic                         imem_req;
    logic [PCW-1:0]               imem_addr;
    logic                         imem_ack;
    logic [INSTRUCTION_WIDTH-1:0] imem_rdata;
    logic                         dmem_req;
    logic [IMMEDIATE_WIDTH-1:0]   dmem_addr;
    logic                         dmem_valid;
    logic [DATABUS_SIZE-1:0]      dmem_rdata;
    logic [INSTRUCTION_WIDTH-1:0] instruction;
    logic                         write_enable;
    logic                         data_control;
    logic [ALU_CONTROL_SIZE-1:0]  control;
    logic [DATABUS_SIZE-1:0]      load_data;
    logic [3:0]                   alu_flags;
    logic [3:0]                   flags_q;
    logic                         busy;
    logic                         halted;
    logic                         error;

    int check_count = 0;
    int err_count   = 0;

    int                      model_pc;
    logic [3:0]              model_flags;
    logic [DATABUS_SIZE-1:0] model_load;

    logic [OPCODE_SIZE-1:0] op_table [6];

    datapath_sequencer #(.PC_WIDTH(PCW), .LOAD_TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .dmem_req     (dmem_req),
        .dmem_addr    (dmem_addr),
        .dmem_valid   (dmem_valid),
        .dmem_rdata   (dmem_rdata),
        .instruction  (instruction),
        .write_enable (write_enable),
        .data_control (data_control),
        .control      (control),
        .load_data    (load_data),
        .alu_flags    (alu_flags),
        .flags_q      (flags_q),
        .busy         (busy),
        .halted       (halted),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) else begin
            err_count++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [ALU_CONTROL_SIZE-1:0] expCtrl(input logic [OPCODE_SIZE-1:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_NONE;
        endcase
    endfunction

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_strobes"}, 32'({imem_req, dmem_req, write_enable, data_control, busy, halted, error}), 32'd0);
        checkOutput({tag, "_ctrl"},    32'(control), 32'd0);
        checkOutput({tag, "_iaddr"},   32'(imem_addr), 32'd0);
        checkOutput({tag, "_daddr"},   32'(dmem_addr), 32'd0);
        checkOutput({tag, "_instr"},   32'(instruction), 32'd0);
        checkOutput({tag, "_ldata"},   32'(load_data), 32'd0);
        checkOutput({tag, "_flags"},   32'(flags_q), 32'd0);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #1;
        checkAllZero("reset");
        tick();
        rst_n = 1'b1;
        model_pc    = 0;
        model_flags = '0;
        model_load  = '0;
    endtask

    // Runs one instruction starting from FETCH; dmemDelay >= TMO means dmem_valid never arrives.
    task automatic applyStimulus(input logic [OPCODE_SIZE-1:0] op, input logic [IMMEDIATE_WIDTH-1:0] imm,
                                 input int ackDelay, input int dmemDelay,
                                 input logic [3:0] flags, input logic [DATABUS_SIZE-1:0] rdata);
        logic [INSTRUCTION_WIDTH-1:0] word;
        word = {op, 4'($urandom_range(0, 15)), imm};
        checkOutput("fetch_req",  32'({imem_req, busy}), 32'(2'b11));
        checkOutput("fetch_addr", 32'(imem_addr), 32'(model_pc));
        for (int i = 0; i < ackDelay; i++) begin
            dmem_valid = 1'b1;
            dmem_rdata = DATABUS_SIZE'($urandom);
            tick();
            checkOutput("fetch_hold", 32'({imem_req, write_enable, busy}), 32'(3'b101));
            checkOutput("fetch_ldata_stable", 32'(load_data), 32'(model_load));
        end
        dmem_valid = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = word;
        alu_flags  = flags;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = '0;
        checkOutput("decode_instr", 32'(instruction), 32'(word));
        checkOutput("decode_quiet", 32'({imem_req, dmem_req, write_enable, data_control, control}), 32'd0);
        tick();
        if (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR}) begin
            checkOutput("exec_we_dc", 32'({write_enable, data_control, busy}), 32'(3'b101));
            checkOutput("exec_ctrl",  32'(control), 32'(expCtrl(op)));
            tick();
            alu_flags   = 4'($urandom);
            model_flags = flags;
            model_pc    = (model_pc + 1) % (1 << PCW);
            checkOutput("exec_flags",   32'(flags_q), 32'(model_flags));
            checkOutput("exec_we_drop", 32'({write_enable, control}), 32'd0);
        end else if (op == OP_NOP) begin
            model_pc = (model_pc + 1) % (1 << PCW);
            checkOutput("nop_no_write", 32'(write_enable), 32'd0);
        end else if (op == OP_HALT) begin
            checkOutput("halt_status", 32'({halted, busy, error, write_enable}), 32'(4'b1000));
            checkOutput("halt_pc",     32'(imem_addr), 32'(model_pc));
        end else if (op == OP_LOAD) begin
            for (int i = 0; i < TMO; i++) begin
                checkOutput("load_req",  32'({dmem_req, busy, write_enable}), 32'(3'b110));
                checkOutput("load_addr", 32'(dmem_addr), 32'(imm));
                dmem_valid = (i == dmemDelay);
                dmem_rdata = (i == dmemDelay) ? rdata : DATABUS_SIZE'($urandom);
                imem_ack   = 1'b1;
                imem_rdata = INSTRUCTION_WIDTH'($urandom);
                tick();
                imem_ack   = 1'b0;
                dmem_valid = 1'b0;
                if (i == dmemDelay) break;
            end
            if (dmemDelay < TMO) begin
                model_load = rdata;
                checkOutput("wb_we_dc",  32'({write_enable, data_control, busy, dmem_req}), 32'(4'b1110));
                checkOutput("wb_ldata",  32'(load_data), 32'(model_load));
                checkOutput("wb_ctrl",   32'(control), 32'(ALU_NONE));
                checkOutput("wb_flags",  32'(flags_q), 32'(model_flags));
                checkOutput("wb_instr",  32'(instruction), 32'(word));
                tick();
                model_pc = (model_pc + 1) % (1 << PCW);
                checkOutput("wb_done", 32'({write_enable, data_control}), 32'd0);
                checkOutput("wb_ldata_hold", 32'(load_data), 32'(model_load));
            end else begin
                checkOutput("timeout_error", 32'({error, busy, dmem_req}), 32'(3'b100));
            end
        end else begin
            checkOutput("bad_op_error", 32'({error, busy, halted, write_enable}), 32'(4'b1000));
        end
    endtask

    initial begin
        op_table   = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LOAD, OP_NOP};
        rst_n      = 1'b0;
        start      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        dmem_valid = 1'b0;
        dmem_rdata = '0;
        alu_flags  = '0;
        doReset();
        tick();
        checkOutput("idle_hold", 32'({busy, imem_req, halted, error}), 32'd0);

        // ADD with a two-cycle ack, then LOAD imm=5 answered after three wait cycles.
        pulseStart();
        applyStimulus(OP_ADD, 8'h12, 2, 0, 4'b1011, '0);
        checkOutput("add_pc_1", 32'(imem_addr), 32'd1);
        applyStimulus(OP_LOAD, 8'd5, 1, 3, 4'h0, 16'h00A5);

        for (int n = 0; n < 24; n++) begin
            int sel;
            int dly;
            sel = int'($urandom_range(0, 5));
            dly = (n == 5 || n == 17) ? TMO - 1 : int'($urandom_range(0, TMO - 1));
            applyStimulus(op_table[sel], 8'($urandom), int'($urandom_range(0, 3)), dly,
                          4'($urandom), DATABUS_SIZE'($urandom));
        end
        applyStimulus(OP_HALT, 8'h00, 1, 0, 4'h0, '0);

        // Restart from HALT clears flags; ADD, NOP, HALT parks with pc=2.
        pulseStart();
        model_pc    = 0;
        model_flags = '0;
        checkOutput("restart_flags", 32'(flags_q), 32'd0);
        applyStimulus(OP_ADD,  8'h01, 0, 0, 4'b0110, '0);
        applyStimulus(OP_NOP,  8'h00, 1, 0, 4'h0, '0);
        applyStimulus(OP_HALT, 8'h00, 0, 0, 4'h0, '0);
        checkOutput("halt_pc_2", 32'(imem_addr), 32'd2);
        pulseStart();
        model_pc    = 0;
        model_flags = '0;

        // 255 NOPs then ADD at 255: pc wraps to 0.
        for (int n = 0; n < 255; n++) begin
            applyStimulus(OP_NOP, 8'($urandom), 0, 0, 4'h0, '0);
        end
        checkOutput("pc_at_255", 32'(imem_addr), 32'd255);
        applyStimulus(OP_ADD, 8'h00, 0, 0, 4'b1111, '0);
        checkOutput("pc_wrap_0", 32'({imem_req, imem_addr}), 32'(9'h100));
        applyStimulus(OP_HALT, 8'h00, 0, 0, 4'h0, '0);

        // Reset while waiting for load data drops everything at once; late valid is ignored.
        pulseStart();
        imem_ack   = 1'b1;
        imem_rdata = {OP_LOAD, 4'h3, 8'h33};
        tick();
        imem_ack   = 1'b0;
        tick();
        tick();
        checkOutput("lw_before_reset", 32'({dmem_req, dmem_addr}), 32'(9'h133));
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("lw_reset");
        dmem_valid = 1'b1;
        dmem_rdata = 16'hBEEF;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        dmem_valid = 1'b0;
        checkOutput("lw_reset_idle", 32'({busy, write_enable, dmem_req, load_data}), 32'd0);
        model_pc    = 0;
        model_flags = '0;
        model_load  = '0;

        // Load that never completes ends in a sticky error.
        pulseStart();
        applyStimulus(OP_LOAD, 8'h44, 0, TMO, 4'h0, '0);
        pulseStart();
        tick();
        checkOutput("error_sticky", 32'({error, busy, imem_req, halted}), 32'(4'b1000));
        doReset();
        checkOutput("error_cleared", 32'(error), 32'd0);

        // Unknown opcode goes to error.
        pulseStart();
        applyStimulus(4'd9, 8'h00, 0, 0, 4'h0, '0);
        doReset();

        // Reset mid-fetch drops imem_req immediately.
        pulseStart();
        checkOutput("mf_req", 32'(imem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mf_reset_req", 32'({imem_req, busy, write_enable}), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule

// File: doc/datapath_sequencer.md
DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 8, instruction address width.
REQ-002 SHALL have parameter LOAD_TIMEOUT, default 15, maximum cycles waited for dmem_valid.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle pulse; begins execution from IDLE or HALT.
REQ-006 SHALL have ports imem_req / imem_addr / imem_ack / imem_rdata  out 1 / out PC_WIDTH / in 1 / in INSTRUCTION_WIDTH  instruction fetch handshake.
REQ-007 SHALL have ports dmem_req / dmem_addr / dmem_valid / dmem_rdata  out 1 / out IMMEDIATE_WIDTH / in 1 / in DATABUS_SIZE  load handshake.
REQ-008 SHALL have ports instruction / write_enable / data_control / control / load_data  out INSTRUCTION_WIDTH / 1 / 1 / ALU_CONTROL_SIZE / DATABUS_SIZE  datapath drive.
REQ-009 SHALL have port alu_flags  input  4  datapath flags.
REQ-010 SHALL have ports flags_q / busy / halted / error  out 4 / 1 / 1 / 1  status.

Function
REQ-011 SHALL implement FSM states IDLE, FETCH, DECODE, EXEC, LOAD_WAIT, LOAD_WB, HALT, ERROR.
REQ-012 IDLE: start=1 -> FETCH with pc=0; otherwise hold.
REQ-013 FETCH: imem_req=1, imem_addr=pc, held until imem_ack=1; on ack, capture imem_rdata into instr_q, -> DECODE.
REQ-014 instruction output SHALL equal instr_q at all times (stable from DECODE until next fetch ack).
REQ-015 DECODE: one cycle; opcode = instr_q[INSTRUCTION_WIDTH-1 -: OPCODE_SIZE]; ALU ops -> EXEC; OP_LOAD -> LOAD_WAIT; OP_NOP -> FETCH, pc+1; OP_HALT -> HALT; any other opcode -> ERROR.
REQ-016 EXEC: one cycle; write_enable=1, data_control=0, control=ALU code mapped from opcode; capture alu_flags into flags_q; -> FETCH, pc+1.
REQ-017 LOAD_WAIT: dmem_req=1, dmem_addr=immediate field (instr_q low IMMEDIATE_WIDTH bits); on dmem_valid=1 capture dmem_rdata into load_data register, -> LOAD_WB.
REQ-018 LOAD_WAIT timeout: counter cleared on entry; if dmem_valid not seen within LOAD_TIMEOUT cycles -> ERROR; valid on the final allowed cycle SHALL win.
REQ-019 LOAD_WB: one cycle; write_enable=1, data_control=1, load_data stable; flags_q unchanged; -> FETCH, pc+1.
REQ-020 write_enable SHALL be 1 only in EXEC and LOAD_WB, exactly one cycle per instruction.
REQ-021 data_control and control SHALL be 0 outside EXEC/LOAD_WB.
REQ-022 pc SHALL wrap from 2^PC_WIDTH-1 to 0 without error.
REQ-023 HALT: halted=1; start=1 -> FETCH with pc=0, flags_q cleared.
REQ-024 ERROR: error=1; sticky, left only by reset; start ignored.
REQ-025 busy SHALL be 1 in FETCH, DECODE, EXEC, LOAD_WAIT, LOAD_WB; start SHALL be ignored while busy.
REQ-026 imem_ack/dmem_valid outside their wait states SHALL be ignored.

Reset
REQ-027 rst_n=0 SHALL asynchronously force IDLE, pc=0, instr_q=0, load_data=0, flags_q=0, timeout counter=0, all outputs 0.
REQ-028 Reset mid-fetch or mid-load SHALL drop imem_req/dmem_req immediately and discard the transaction; no write_enable pulse.

Structure
REQ-029 Shared package SHALL hold INSTRUCTION_WIDTH, OPCODE_SIZE, IMMEDIATE_WIDTH, REGFILE_ADDR_BITS, DATABUS_SIZE, ALU_CONTROL_SIZE, opcode constants (OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_LOAD=8, OP_NOP=14, OP_HALT=15), ALU control constants, and the FSM state enum.
REQ-030 Opcode-to-ALU-control mapping SHALL be a separate combinational sub-module alu_op_map; all else in one module.

Verification
REQ-031 start, fetch OP_ADD with imem_ack after 2 cycles -> single write_enable pulse, data_control=0, control=ALU_ADD, flags_q=alu_flags, pc 0->1.
REQ-032 OP_LOAD imm=5, dmem_valid after 3 cycles with rdata=0xA5 -> dmem_addr=5, LOAD_WB write_enable=1, data_control=1, load_data=0xA5.
REQ-033 OP_LOAD, dmem_valid never -> ERROR after exactly 15 wait cycles, error=1, start ignored until rst_n pulse.
REQ-034 program ADD, NOP, HALT -> one write pulse, halted=1 with pc=2; start -> refetch from address 0.
REQ-035 rst_n low during LOAD_WAIT -> outputs 0 same cycle, IDLE; later dmem_valid ignored.
REQ-036 pc preloaded path: 255 NOP instructions then ADD at 255 -> next fetch address 0.
